// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the chunk-serial add/subtract unit.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of chunk passes needed for one operation.
    function automatic int calc_nchunk(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 0;
    endfunction

    // Chunk index counter width; a single-chunk build still gets one bit.
    function automatic int calc_idx_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder. Besides the sum and carry-out it
// exposes the carry into its MSB so the caller can form signed overflow.
module chunk_adder #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    // One full adder per bit, carries rippling upward.
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[CHUNK];
    assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/chunk_serial_adder.sv
// Multi-cycle add/subtract: WIDTH-bit operands consumed CHUNK bits per clock
// through one chunk_adder, carry held in a register between passes.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one chunk added per clock, low chunk first
// DONE  | single-cycle done pulse; a start here launches immediately
module chunk_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             Ovf
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = calc_idx_w(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("chunk_serial_adder: WIDTH must be a positive multiple of CHUNK");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh, b_sh, res_sh, res_nxt;
    logic               carry_r;
    logic [IDX_W-1:0]   idx;
    logic               accept, last;
    logic [CHUNK-1:0]   csum;
    logic               cout, cmsb;

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_sh[CHUNK-1:0]),
        .b    (b_sh[CHUNK-1:0]),
        .cin  (carry_r),
        .sum  (csum),
        .cout (cout),
        .cmsb (cmsb)
    );

    // New chunk enters at the top; after NCHUNK passes the result is aligned.
    // Written as a shift of the concatenation so CHUNK == WIDTH needs no
    // special case.
    assign res_nxt = WIDTH'({csum, res_sh} >> CHUNK);

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode plus the accept/last strobes for the datapath.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (idx == LAST_IDX) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture on accept, then one chunk shifted out per RUN cycle.
    // Subtraction is folded in at capture: invert B and force carry-in to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry_r <= 1'b0;
            idx     <= '0;
        end else if (accept) begin
            a_sh    <= A;
            b_sh    <= sub ? ~B : B;
            carry_r <= sub ? 1'b1 : Cin;
            idx     <= '0;
        end else if (state_q == RUN) begin
            a_sh    <= a_sh >> CHUNK;
            b_sh    <= b_sh >> CHUNK;
            res_sh  <= res_nxt;
            carry_r <= cout;
            idx     <= idx + IDX_W'(1);
        end
    end

    // Result registers move only on the completion edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Sum   <= '0;
            Carry <= 1'b0;
            Ovf   <= 1'b0;
        end else if (last) begin
            Sum   <= res_nxt;
            Carry <= cout;
            Ovf   <= cmsb ^ cout;
        end
    end

endmodule

// File: doc/chunk_serial_adder.md
Name: chunk_serial_adder

Overview:
- Parametrised multi-cycle add/subtract unit; successor to the team's fixed 2-bit ripple full adder.
- Processes a WIDTH-bit operand pair CHUNK bits per clock through one ripple chunk adder. Carry is held in a register between chunks.
- Start/busy/done handshake; outputs sum, carry-out and signed overflow.
- Used where area matters more than latency, e.g. accumulators and address arithmetic in slow control paths.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 2, bits added per clock; CHUNK = WIDTH is legal (single-cycle operation).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only when not busy.
sub  input  1  0 = A + B + Cin; 1 = A - B (A + ~B + 1); Cin ignored.
A  input  WIDTH  operand A, captured on accepted start.
B  input  WIDTH  operand B, captured on accepted start.
Cin  input  1  carry-in for add mode.
busy  output  1  operation in progress.
done  output  1  one-cycle pulse; result valid.
Sum  output  WIDTH  result, held until the next completion.
Carry  output  1  carry-out of MSB; in sub mode 1 = no borrow.
Ovf  output  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. clk and rst_n are named as the codebase does.
- Reset: state = IDLE. busy, done, Sum, Carry and Ovf = 0. All working registers = 0.
- NCHUNK = WIDTH/CHUNK. An illegal parameter combination is an elaboration error.
- States are IDLE, RUN and DONE.
- IDLE, start = 1 at edge t0:
  - Capture A. Capture B, or ~B when sub = 1.
  - Carry register = sub ? 1 : Cin. chunk index = 0. Go to RUN. busy = 1 from t0.
- RUN, each edge:
  - Add the low CHUNK bits of the shift registers plus the carry register.
  - Shift the chunk sum into the top of the result shift register. Update the carry register and increment the index.
  - On the edge where index = NCHUNK-1 (edge t0+NCHUNK):
    - Load Sum. Load Carry from the chunk carry-out. Load Ovf from the chunk's MSB carry-in XOR carry-out.
    - Go to DONE: busy = 0, done = 1.
- Latency: done is high in the cycle after edge t0+NCHUNK, i.e. NCHUNK cycles after start is accepted.
- DONE: lasts exactly one cycle.
  - start = 1 in DONE is accepted, behaving as in IDLE: back-to-back operations, no bubble.
  - Otherwise go to IDLE.
- Boundary conditions:
  - start while in RUN is ignored. Inputs A, B, sub and Cin may change freely while busy.
  - Sum, Carry and Ovf change only on the completion edge and are stable otherwise, including across IDLE.
  - NCHUNK = 1: RUN lasts one edge; done appears one cycle after start.
  - rst_n low mid-RUN: immediate return to IDLE, outputs cleared, no done pulse. The first start after reset release behaves normally.
- Arithmetic: modulo 2^WIDTH. No saturation.

Decomposition:
- Package adder_pkg holds:
  - the state encoding constants (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2);
  - a function computing NCHUNK and the index counter width.
- Sub-module chunk_adder, parametrised by CHUNK:
  - combinational ripple of full adders;
  - outputs the chunk sum, carry-out, and carry into the chunk MSB (for Ovf).
- The top level holds the FSM, shift registers, carry register and output registers.

Test Plan:
WIDTH=16, CHUNK=2, add 0xFFFF + 0x0001, Cin=0 -> Sum=0x0000, Carry=1, Ovf=0; done exactly 8 cycles after start; busy high those 8 cycles.
Add 0x7FFF + 0x0001, Cin=0 -> Sum=0x8000, Carry=0, Ovf=1; then add 0x1234 + 0x4321, Cin=1 -> Sum=0x5556, Carry=0, Ovf=0.
sub=1, 0x0005 - 0x0007 -> Sum=0xFFFE, Carry=0, Ovf=0; sub=1, 0x8000 - 0x0001 -> Sum=0x7FFF, Carry=1, Ovf=1.
start pulsed again at cycle 3 of RUN with different operands -> ignored, first result unchanged; start held in DONE -> second operation begins with no idle cycle, done 8 cycles later.
rst_n asserted mid-RUN (cycle 4) -> outputs 0 immediately, no done; after release, 0x0010 + 0x0020 -> Sum=0x0030.
WIDTH=8, CHUNK=8: 0x80 + 0x80 -> Sum=0x00, Carry=1, Ovf=1, done 1 cycle after start; random 1000-op compare against a reference model for (16,2), (16,4) and (12,3).
